corescore_stream_arbiter: RTL and testbench
===========================================

CORESCORE_STREAM_ARBITER -- requirements
Module: corescore_stream_arbiter

Interface
REQ-001 Parameter N, default 4: number of requester streams; legal 2..16.
REQ-002 Parameter TIMEOUT, default 255: stall-cycle limit, used only when CORESCORE_ARB_TIMEOUT_EN is defined; legal 1..65535.
REQ-003 i_clk  input  1  single clock for all logic; rising edge.
REQ-004 i_rst_n  input  1  asynchronous reset, active-low.
REQ-005 i_tdata  input  8*N  requester data; requester k occupies bits [8k+7:8k].
REQ-006 i_tlast  input  N  requester end-of-packet flags, bit k = requester k.
REQ-007 i_tvalid  input  N  requester valid flags.
REQ-008 o_tready  output  N  requester ready flags.
REQ-009 o_tdata  output  8  merged data towards emitter.
REQ-010 o_tlast  output  1  merged end-of-packet.
REQ-011 o_tvalid  output  1  merged valid.
REQ-012 i_tready  input  1  emitter ready.
REQ-013 o_grant  output  clog2(N)  index of requester currently owning the output.
REQ-014 o_busy  output  1  high while a requester owns the output (state LOCKED).
REQ-015 o_timeout  output  1  one-cycle pulse on forced release.

Function
REQ-016 Two states: IDLE, LOCKED.
REQ-017 IDLE: o_tvalid=0, o_tready=0 (all bits), o_busy=0, o_tdata=0, o_tlast=0.
REQ-018 IDLE with any i_tvalid bit set: select first set bit searching upward from pointer P, wrapping N-1 -> 0; next cycle enter LOCKED with o_grant = selected index.
REQ-019 IDLE with no i_tvalid set: remain IDLE; o_grant and P unchanged.
REQ-020 LOCKED: o_tdata, o_tlast, o_tvalid combinationally follow requester o_grant; o_tready[o_grant]=i_tready; all other o_tready bits 0.
REQ-021 LOCKED: transfer occurs when o_tvalid & i_tready; data passes with zero added latency.
REQ-022 LOCKED: transfer with o_tlast=1 -> next cycle IDLE, P = (o_grant+1) mod N.
REQ-023 Ownership never changes mid-packet; other requesters' i_tvalid ignored while LOCKED.
REQ-024 Arbitration costs exactly one idle cycle between packets; sustained throughput with all requesters busy is L/(L+1) for packet length L beads.
REQ-025 Requester deasserting i_tvalid while LOCKED retains ownership (subject to REQ-032).
REQ-026 Fairness: with all N requesters continuously valid, grants follow 0,1,...,N-1,0,... from reset.
REQ-027 o_grant holds its last value in IDLE.
REQ-028 o_timeout=0 except as in REQ-032.

Reset
REQ-029 i_rst_n low asynchronously forces: state IDLE, P=0, o_grant=0, o_busy=0, o_tvalid=0, o_tready=0, o_tdata=0, o_tlast=0, o_timeout=0, stall counter 0.
REQ-030 Reset mid-packet abandons the packet; no partial-packet recovery; first post-reset grant searches from index 0.
REQ-031 Release of i_rst_n is synchronous to i_clk externally; block leaves IDLE no earlier than first rising edge with i_rst_n high.

Configuration
REQ-032 Macro CORESCORE_ARB_TIMEOUT_EN defined: in LOCKED a 16-bit counter increments each cycle i_tvalid[o_grant]=0, clears on any cycle it is 1; on reaching TIMEOUT the block enters IDLE next cycle, P=(o_grant+1) mod N, o_timeout pulses high for that one cycle, counter clears.
REQ-033 Macro undefined: no counter implemented, o_timeout tied 0, release only per REQ-022; parameter TIMEOUT ignored.

Verification
REQ-034 Single requester 2 sends 3-byte packet 0x41,0x42,0x43 (tlast on 0x43), i_tready=1 -> o_grant=2 one cycle after valid, three output beats identical, IDLE next cycle.
REQ-035 All 4 requesters valid, 2-byte packets, i_tready=1 -> grant order 0,1,2,3,0; one idle cycle between packets; 8 beats in 12 cycles.
REQ-036 Requester 1 locked, requester 0 asserts valid mid-packet, i_tready toggling 1/0 -> no byte of requester 0 appears before requester 1 tlast; o_tready[0]=0 throughout.
REQ-037 i_rst_n low during beat 2 of a 4-byte packet from requester 3 -> all outputs 0 immediately (before next edge); after release, with requesters 0 and 3 valid, requester 0 granted first.
REQ-038 CORESCORE_ARB_TIMEOUT_EN, TIMEOUT=4: requester 1 locked then drops i_tvalid -> o_timeout pulses after 4 stall cycles, requester 2 (valid) granted next; without macro, requester 1 stays locked 100 cycles, o_timeout=0.

Source files
------------

// File: rtl/corescore_stream_arbiter.sv
// corescore_stream_arbiter: round-robin packet arbiter merging N byte streams onto one output.
// Define CORESCORE_ARB_TIMEOUT_EN to force release of a requester that stalls for TIMEOUT cycles.
module corescore_stream_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [8*N-1:0]       i_tdata,
    input  logic [N-1:0]         i_tlast,
    input  logic [N-1:0]         i_tvalid,
    output logic [N-1:0]         o_tready,
    output logic [7:0]           o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 i_tready,
    output logic [$clog2(N)-1:0] o_grant,
    output logic                 o_busy,
    output logic                 o_timeout
);
    localparam int GW = $clog2(N);

    if (N < 2 || N > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("corescore_stream_arbiter: N must be 2..16 and TIMEOUT 1..65535");
    end

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] grant, grant_nxt, ptr, ptr_nxt, grant_inc;
    logic          last_beat;

    // First valid requester at or above p, wrapping; the downward loop leaves the nearest one.
    function automatic logic [GW-1:0] pick(input logic [N-1:0] v, input logic [GW-1:0] p);
        logic [GW-1:0] k;
        pick = p;
        for (int i = N - 1; i >= 0; i--) begin
            k = GW'((int'(p) + i) % N);
            if (v[k]) pick = k;
        end
    endfunction

    assign grant_inc = GW'((int'(grant) + 1) % N);
    assign o_busy    = state == LOCKED;
    assign o_grant   = grant;
    assign o_tvalid  = o_busy & i_tvalid[grant];
    assign o_tlast   = o_busy & i_tlast[grant];
    assign o_tdata   = o_busy ? i_tdata[8*grant +: 8] : 8'h00;
    assign o_tready  = o_busy ? (N'(i_tready) << grant) : '0;
    assign last_beat = o_tvalid & i_tready & o_tlast;

`ifdef CORESCORE_ARB_TIMEOUT_EN
    logic [15:0] stall_cnt, stall_cnt_nxt;
    logic        timeout_q, timeout_nxt;

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        ptr_nxt       = ptr;
        stall_cnt_nxt = '0;
        timeout_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (|i_tvalid) begin
                    state_nxt = LOCKED;
                    grant_nxt = pick(i_tvalid, ptr);
                end
            end
            default: begin
                if (last_beat) begin
                    state_nxt = IDLE;
                    ptr_nxt   = grant_inc;
                end else if (!i_tvalid[grant]) begin
                    if (stall_cnt + 16'd1 == 16'(TIMEOUT)) begin
                        state_nxt   = IDLE;
                        ptr_nxt     = grant_inc;
                        timeout_nxt = 1'b1;
                    end else begin
                        stall_cnt_nxt = stall_cnt + 16'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign o_timeout = timeout_q;
`else
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (|i_tvalid) begin
                    state_nxt = LOCKED;
                    grant_nxt = pick(i_tvalid, ptr);
                end
            end
            default: begin
                if (last_beat) begin
                    state_nxt = IDLE;
                    ptr_nxt   = grant_inc;
                end
            end
        endcase
    end

    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
        end
    end
endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// tb_corescore_stream_arbiter: directed checks of the round-robin stream arbiter (N=4, TIMEOUT=4).
module tb_corescore_stream_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tdata;
    logic [3:0]  tlast, tvalid, o_tready;
    logic        tready;
    logic [7:0]  o_tdata;
    logic        o_tlast, o_tvalid, o_busy, o_timeout;
    logic [1:0]  o_grant;
    int          n_checks = 0;
    int          n_fail = 0;

    corescore_stream_arbiter #(.N(4), .TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(tvalid),
        .o_tready(o_tready), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
        .i_tready(tready), .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt[4];
        int beats;
        int exp_g[8];
        int b1;
        bit done;
        int bad;
        exp_g = '{0, 0, 1, 1, 2, 2, 3, 3};
        rst_n = 1'b0; tdata = '0; tlast = '0; tvalid = '0; tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_grant", o_grant, 0);
        check("rst_tvalid", o_tvalid, 0);
        check("rst_tready", o_tready, 0);
        check("rst_tdata", o_tdata, 0);
        check("rst_timeout", o_timeout, 0);

        // single requester 2, three-byte packet
        @(negedge clk);
        rst_n = 1'b1;
        tvalid = 4'b0100; tdata = 32'h0041_0000;
        #1;
        check("idle_tvalid", o_tvalid, 0);
        check("idle_tready", o_tready, 0);
        tick;
        check("r2_grant", o_grant, 2);
        check("r2_busy", o_busy, 1);
        check("r2_tready", o_tready, 4'b0100);
        check("r2_b0", o_tdata, 8'h41);
        tick;
        tdata = 32'h0042_0000;
        #1;
        check("r2_b1", o_tdata, 8'h42);
        tick;
        tdata = 32'h0043_0000; tlast = 4'b0100;
        #1;
        check("r2_b2", o_tdata, 8'h43);
        check("r2_tlast", o_tlast, 1);
        tick;
        tvalid = '0; tlast = '0;
        #1;
        check("r2_end_busy", o_busy, 0);
        check("r2_end_grant", o_grant, 2);
        check("r2_end_tdata", o_tdata, 0);

        // all four requesters busy with two-byte packets
        reset_dut;
        tvalid = 4'hf;
        cnt = '{0, 0, 0, 0};
        beats = 0;
        for (int c = 0; c < 12; c++) begin
            for (int k = 0; k < 4; k++) begin
                tdata[8*k +: 8] = 8'(16 * k + cnt[k]);
                tlast[k] = (cnt[k] % 2) == 1;
            end
            #1;
            if (o_tvalid && tready) begin
                if (beats < 8) begin
                    check("rr_grant", o_grant, exp_g[beats]);
                    check("rr_data", o_tdata, 16 * exp_g[beats] + beats % 2);
                end
                cnt[o_grant]++;
                beats++;
            end
            tick;
        end
        check("rr_beats", beats, 8);
        check("rr_gap_busy", o_busy, 0);
        tick;
        check("rr_wrap_grant", o_grant, 0);
        check("rr_wrap_busy", o_busy, 1);

        // requester 1 keeps ownership while requester 0 competes, emitter ready toggling
        reset_dut;
        tvalid = 4'b0010; tlast = '0; tdata = 32'h0000_1000; tready = 1'b1;
        tick;
        check("lk_grant", o_grant, 1);
        tvalid = 4'b0011; tdata[7:0] = 8'hA0;
        b1 = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tready = (c % 2) == 0;
            tdata[15:8] = 8'(8'h10 + b1);
            tlast[1] = b1 == 3;
            #1;
            check("lk_tready0", o_tready[0], 0);
            if (o_tvalid && tready) begin
                check("lk_data", o_tdata, 8'h10 + b1);
                if (b1 == 3) done = 1'b1;
                b1++;
            end
            tick;
        end
        check("lk_done", done, 1);
        tvalid = 4'b0001; tlast = '0; tready = 1'b1;
        tick;
        check("lk_next_grant", o_grant, 0);

        // reset during beat 2 of a packet from requester 3
        reset_dut;
        tvalid = 4'b1000; tlast = '0; tdata = 32'h3000_0000; tready = 1'b1;
        tick;
        check("ar_grant", o_grant, 3);
        tick;
        tdata[31:24] = 8'h31;
        tick;
        tdata[31:24] = 8'h32; tlast = 4'b1000;
        #1;
        check("ar_mid", o_tdata, 8'h32);
        rst_n = 1'b0;
        #1;
        check("ar_tvalid", o_tvalid, 0);
        check("ar_tready", o_tready, 0);
        check("ar_tdata", o_tdata, 0);
        check("ar_tlast", o_tlast, 0);
        check("ar_busy", o_busy, 0);
        check("ar_grant0", o_grant, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tvalid = 4'b1001; tlast = '0;
        tick;
        check("ar_first_grant", o_grant, 0);
        check("ar_first_busy", o_busy, 1);

        // requester 1 stalls mid-packet while requester 2 waits
        reset_dut;
        tvalid = 4'b0010; tlast = '0; tdata = 32'h0000_5500; tready = 1'b1;
        tick;
        check("to_lock", o_grant, 1);
        tick;
        tvalid = 4'b0100;
`ifdef CORESCORE_ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            #1;
            check("to_wait_busy", o_busy, 1);
            check("to_wait_pulse", o_timeout, 0);
            tick;
        end
        check("to_pulse", o_timeout, 1);
        check("to_release", o_busy, 0);
        tick;
        check("to_next_grant", o_grant, 2);
        check("to_pulse_end", o_timeout, 0);
`else
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (!o_busy || o_grant != 2'd1 || o_timeout) bad++;
            tick;
        end
        check("hold_bad_cycles", bad, 0);
        check("hold_grant", o_grant, 1);
        check("hold_timeout", o_timeout, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
